// File: rtl/cs_trgt_xchg_pkg.sv
// Shared types and constants for the target-side vector exchange controller.
package cs_trgt_xchg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RX,
        APPLY,
        DONE,
        ERR
    } cs_xchg_state_t;

    localparam int CS_MODE_GET    = 0;
    localparam int CS_MODE_PUT    = 1;
    localparam int CS_MODE_PUTGET = 2;

    // Lowest set bit of a request vector; channel 0 has the highest priority.
    function automatic logic [3:0] cs_lowest_idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cs_wd_cnt.sv
// Watchdog counter: clears on clr, counts on inc, saturates at LIMIT and flags it on tc.
module cs_wd_cnt #(
    parameter int LIMIT = 10000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/cs_trgt_xchg.sv
// Target-side vector exchange controller: freezes mission clocks, uploads/downloads vectors.
// Optional watchdog and ERR state are built when CS_TRGT_WATCHDOG_EN is defined.
module cs_trgt_xchg
    import cs_trgt_xchg_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int DW       = 8,
    parameter  int MODE     = 2,
    parameter  int WD_LIMIT = 10000,
    localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_CH-1:0]   mclk_i,
    output logic [N_CH-1:0]   freeze_clk_o,
    output logic [N_CH-1:0]   wen_o,
    output logic [N_CH*DW-1:0] data_o,
    input  logic              up_valid_i,
    input  logic [DW-1:0]     up_data_i,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [CW-1:0]     tx_ch_o,
    output logic [DW:0]       tx_data_o,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic [CW-1:0]     rx_ch_i,
    input  logic [DW:0]       rx_data_i,
    output logic              err_o,
    output logic [CW-1:0]     err_ch_o,
    output logic [N_CH-1:0]   ovr_o
);

    cs_xchg_state_t state, state_nxt;

    logic [N_CH-1:0]    mclk_d, mclk_edge, pending, clr_mask, ovr_q, wen_q;
    logic [N_CH*DW-1:0] data_q;
    logic [CW-1:0]      cur;
    logic [DW:0]        tx_data_q, rx_cap;
    logic               tx_hs, rx_hs, wd_tc;

    assign mclk_edge = mclk_i & ~mclk_d;
    assign clr_mask  = (state == DONE) ? (N_CH'(1) << cur) : '0;
    assign tx_hs     = (state == SEND) & tx_ready_i;
    assign rx_hs     = (state == WAIT_RX) & rx_valid_i & (rx_ch_i == cur);

    // A new edge wins over the DONE clear on the same channel and is not an overrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mclk_d  <= '0;
            pending <= '0;
            ovr_q   <= '0;
        end else begin
            mclk_d  <= mclk_i;
            pending <= (pending & ~clr_mask) | mclk_edge;
            ovr_q   <= ovr_q | (mclk_edge & pending & ~clr_mask);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending) state_nxt = (MODE != CS_MODE_GET) ? SEND : WAIT_RX;
            SEND:    if (wd_tc) state_nxt = ERR;
                     else if (tx_hs) state_nxt = (MODE == CS_MODE_PUTGET) ? WAIT_RX : DONE;
            WAIT_RX: if (wd_tc) state_nxt = ERR;
                     else if (rx_hs) state_nxt = APPLY;
            APPLY:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Upload vector is captured once on leaving IDLE so it stays stable while tx_valid_o is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur       <= '0;
            tx_data_q <= '0;
            rx_cap    <= '0;
            wen_q     <= '0;
            data_q    <= '0;
        end else begin
            if (state == IDLE && |pending) begin
                cur <= CW'(cs_lowest_idx(16'(pending)));
                if (MODE != CS_MODE_GET) tx_data_q <= {up_valid_i, up_data_i};
            end
            if (rx_hs) rx_cap <= rx_data_i;
            if (state == APPLY) begin
                wen_q[cur]             <= rx_cap[DW];
                data_q[cur*DW +: DW]   <= rx_cap[DW-1:0];
            end
        end
    end

`ifdef CS_TRGT_WATCHDOG_EN
    logic          wd_clr, wd_inc, err_q;
    logic [CW-1:0] err_ch_q;

    assign wd_inc = (state == SEND) || (state == WAIT_RX);
    assign wd_clr = (state_nxt != state) && ((state_nxt == SEND) || (state_nxt == WAIT_RX));

    cs_wd_cnt #(
        .LIMIT(WD_LIMIT)
    ) u_wd_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr  (wd_clr),
        .inc  (wd_inc),
        .tc   (wd_tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q    <= 1'b0;
            err_ch_q <= '0;
        end else if (wd_inc && wd_tc) begin
            err_q    <= 1'b1;
            err_ch_q <= cur;
        end
    end

    assign err_o    = err_q;
    assign err_ch_o = err_ch_q;
`else
    assign wd_tc    = 1'b0;
    assign err_o    = 1'b0;
    assign err_ch_o = '0;
`endif

    assign freeze_clk_o = pending;
    assign wen_o        = wen_q;
    assign data_o       = data_q;
    assign ovr_o        = ovr_q;
    assign tx_valid_o   = (state == SEND);
    assign tx_ch_o      = cur;
    assign tx_data_o    = tx_data_q;
    assign rx_ready_o   = rx_hs;

endmodule

// File: doc/cs_trgt_xchg.md
# cs_trgt_xchg

Target-side vector exchange controller for the co-simulation shunt. It sits between the target's SUT partition and the transport fringe, one level below the fringe DPI layer. For each of `N_CH` mission clocks it freezes the clock on every rising edge, uploads the SUT output vector, waits for the matching download vector, applies it to the channel outputs and releases the clock. It replaces the fixed 3-channel, 8-bit target interface with a parametrised, synthesizable FSM that has a watchdog and overrun detection.

## Interface
Parameters:
- `N_CH`, 4: number of mission clocks / download channels (1..16).
- `DW`, 8: payload width. Transported vectors are `DW+1` bits: `{wen, data}` down, `{valid, data}` up.
- `MODE`, 2: 0 = get-only, 1 = put-only, 2 = put-then-get.
- `WD_LIMIT`, 10000: watchdog limit in `clk_i` cycles.

Ports (clock and reset first):
- `clk_i`  in  1  utility clock; the only clock of the block.
- `rst_i`  in  1  asynchronous reset, active-high.
- `mclk_i`  in  `N_CH`  mission clock levels, sampled on `clk_i`.
- `freeze_clk_o`  out  `N_CH`  per-channel mission clock hold.
- `wen_o`  out  `N_CH`  downloaded write enables.
- `data_o`  out  `N_CH*DW`  downloaded data; channel c occupies `[c*DW +: DW]`.
- `up_valid_i`  in  1  SUT upload valid.
- `up_data_i`  in  `DW`  SUT upload data.
- `tx_valid_o`  out  1  upload beat valid.
- `tx_ready_i`  in  1  fringe accepts the upload beat.
- `tx_ch_o`  out  `$clog2(N_CH)`  upload channel index.
- `tx_data_o`  out  `DW+1`  upload vector `{valid, data}`.
- `rx_valid_i`  in  1  download beat valid.
- `rx_ready_o`  out  1  download beat accepted.
- `rx_ch_i`  in  `$clog2(N_CH)`  download channel index.
- `rx_data_i`  in  `DW+1`  download vector `{wen, data}`.
- `err_o`  out  1  sticky watchdog error.
- `err_ch_o`  out  `$clog2(N_CH)`  channel that timed out.
- `ovr_o`  out  `N_CH`  sticky per-channel overrun.

## Operation
- **Edge detection:** `mclk_d` is `mclk_i` registered. The edge is `mclk_i & ~mclk_d`. An edge on channel c sets `pending[c]` and `freeze_clk_o[c]` on the next `clk_i` edge.
- **Overrun:** an edge on a channel whose `pending` bit is already set sets `ovr_o[c]` (sticky). The edge is not queued a second time.
- **FSM state IDLE:** if `pending != 0`, latch `cur` = lowest set index. Go to SEND if `MODE != 0`, otherwise to WAIT_RX.
- **FSM state SEND:** on entry, capture `{up_valid_i, up_data_i}` into `tx_data_o`. Assert `tx_valid_o` with `tx_ch_o = cur` and hold it until `tx_valid_o & tx_ready_i`. Then go to WAIT_RX if `MODE == 2`, or to DONE if `MODE == 1`.
- **FSM state WAIT_RX:** `rx_ready_o = rx_valid_i & (rx_ch_i == cur)`, combinational. Beats for any other channel are stalled, never dropped. On a handshake, capture `rx_data_i` and go to APPLY.
- **FSM state APPLY:** write `{wen_o[cur], data_o[cur]}` from the captured vector; go to DONE. Outputs of the other channels hold their values.
- **FSM state DONE:** clear `pending[cur]` and `freeze_clk_o[cur]`; return to IDLE.
- **FSM state ERR:** terminal until reset. All freezes stay asserted and no handshakes are issued.
- **Watchdog:** the counter clears on entry to SEND or WAIT_RX and increments on each cycle spent in either state. When `count == WD_LIMIT`: set `err_o`, set `err_ch_o = cur`, go to ERR.
- **Reset values:** all outputs 0, `pending` = 0, FSM in IDLE, counters 0.
- **Reset mid-handshake:** the beat is abandoned. The fringe must re-issue it after reset.

## Timing
- Minimum latency from `mclk_i` rising to `freeze_clk_o` asserted: 1 cycle.
- Minimum freeze duration, get-only mode with `rx_valid_i` already high: IDLE, WAIT_RX, APPLY, DONE, so `freeze_clk_o` drops 4 cycles after it rises.
- Put-then-get mode adds at least 1 cycle for SEND.
- Upload data is sampled on the cycle IDLE exits to SEND and is held stable while `tx_valid_o` is high.
- When a new edge and a DONE clear hit the same channel in the same cycle, the set wins: `pending` and `freeze_clk_o` stay 1 and no overrun is flagged.

## Configuration
- `CS_TRGT_WATCHDOG_EN` defined: the watchdog counter, the ERR state, `err_o` and `err_ch_o` are implemented as specified above.
- `CS_TRGT_WATCHDOG_EN` undefined: no counter and no ERR state; SEND and WAIT_RX wait indefinitely. `err_o` and `err_ch_o` are tied to 0.

## Structure
- Package `cs_trgt_xchg_pkg` holds:
  - the state enum `cs_xchg_state_t` (IDLE, SEND, WAIT_RX, APPLY, DONE, ERR);
  - the mode constants `CS_MODE_GET`, `CS_MODE_PUT`, `CS_MODE_PUTGET`.
- One sub-module, `cs_wd_cnt`: the watchdog counter with `clr`, `inc` and a terminal-count output. It is instantiated only under `CS_TRGT_WATCHDOG_EN`.

## Test plan
- **Single channel, put-then-get:** `MODE`=2, `N_CH`=4, `DW`=8. A `mclk_i[0]` edge with `up_data_i`=0xA5, `up_valid_i`=1 produces a tx beat of 0x1A5 on ch0. Drive rx ch0 with 0x13C: `wen_o[0]`=1, `data_o[0]`=0x3C, and `freeze_clk_o[0]` falls.
- **Priority:** edges on ch2 and ch1 in the same cycle serve ch1 first, then ch2. An rx beat for ch2 offered first is stalled (`rx_ready_o`=0) until ch1 completes.
- **Overrun:** a second `mclk_i[3]` edge while `pending[3]`=1 sets `ovr_o` to 0x8. Only one exchange runs.
- **Watchdog:** `WD_LIMIT`=16 with no rx beat on ch1 gives `err_o`=1 and `err_ch_o`=1 after 16 cycles in WAIT_RX; `freeze_clk_o[1]` stays 1.
- **Reset mid-SEND:** asserting `rst_i` while `tx_valid_o`=1 forces all outputs to 0 immediately (asynchronously). After release the block is in IDLE with `pending`=0.
- **Get-only mode:** `MODE`=0 issues no tx beats. The freeze-to-release time with `rx_valid_i` held high is exactly 4 cycles.
